// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu: RV32 execute stage with forwarding, branch resolution and an RV32M unit.
// Define MDU_FAST_MUL_EN for a single-cycle multiplier; otherwise multiply is iterative.
`timescale 1ns/1ps
module ex_stage_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            ex_mem_regwrite,
    input  logic            mem_wb_regwrite,
    input  logic [4:0]      ex_mem_rd,
    input  logic [4:0]      mem_wb_rd,
    input  logic [XLEN-1:0] ex_mem_data,
    input  logic [XLEN-1:0] mem_wb_data,
    input  logic [3:0]      alu_ctrl,
    input  logic            md_en,
    input  logic [2:0]      funct3,
    input  logic            alu_src,
    input  logic            alu_src_a,
    input  logic            is_lui,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            branch,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_pc,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            branch_resolve
);

    localparam int SW = $clog2(XLEN);
    localparam logic [SW-1:0] LAST = SW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY} state_t;

    state_t          state;
    logic [SW-1:0]   cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0] quo, dsr, m_rs2;
    logic            m_neg_q, m_neg_r, m_rw;
    logic [1:0]      m_op;
    logic [4:0]      m_rd;

    logic            accept, is_cf, taken, cond;
    logic            hit1_ex, hit1_wb, hit2_ex, hit2_wb;
    logic [XLEN-1:0] fwd1, fwd2, op_a, op_b, alu_res;
    logic [XLEN-1:0] pc4, target, result_c;
    logic [SW-1:0]   shamt;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready & ~flush;

    assign hit1_ex = ex_mem_regwrite & (ex_mem_rd != 5'd0) & (ex_mem_rd == rs1_addr);
    assign hit1_wb = mem_wb_regwrite & (mem_wb_rd != 5'd0) & (mem_wb_rd == rs1_addr);
    assign hit2_ex = ex_mem_regwrite & (ex_mem_rd != 5'd0) & (ex_mem_rd == rs2_addr);
    assign hit2_wb = mem_wb_regwrite & (mem_wb_rd != 5'd0) & (mem_wb_rd == rs2_addr);

    assign fwd1 = hit1_ex ? ex_mem_data : (hit1_wb ? mem_wb_data : rs1_data);
    assign fwd2 = hit2_ex ? ex_mem_data : (hit2_wb ? mem_wb_data : rs2_data);

    assign op_a  = is_lui ? '0 : (alu_src_a ? pc : fwd1);
    assign op_b  = alu_src ? imm : fwd2;
    assign shamt = op_b[SW-1:0];

    always_comb begin
        case (alu_ctrl)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = op_a << shamt;
            4'd6:    alu_res = op_a >> shamt;
            4'd7:    alu_res = XLEN'($signed(op_a) >>> shamt);
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (funct3)
            3'd0:    cond = (fwd1 == fwd2);
            3'd1:    cond = (fwd1 != fwd2);
            3'd4:    cond = $signed(fwd1) < $signed(fwd2);
            3'd5:    cond = $signed(fwd1) >= $signed(fwd2);
            3'd6:    cond = fwd1 < fwd2;
            3'd7:    cond = fwd1 >= fwd2;
            default: cond = 1'b0;
        endcase
    end

    assign is_cf  = ~md_en & (is_jal | is_jalr | branch);
    assign taken  = is_jal | is_jalr | (branch & cond);
    assign pc4    = pc + XLEN'(4);
    assign target = is_jalr ? ((fwd1 + imm) & ~XLEN'(1)) : (pc + imm);

    assign redirect_pc    = taken ? target : pc4;
    assign branch_resolve = accept & is_cf;
    assign redirect       = accept & is_cf &
                            ((pred_taken != taken) | (taken & (pred_pc != target)));

    // M-extension operand conditioning: work on magnitudes, fix signs at the end
    logic            md_div, sgn_a, sgn_b, neg_a, neg_b;
    logic            div_zero, div_ovf, go_div, go_mul;
    logic [XLEN-1:0] abs_a, abs_b, md_fast;

    assign md_div   = funct3[2];
    assign sgn_a    = md_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign sgn_b    = md_div ? ~funct3[0] : ~funct3[1];
    assign neg_a    = sgn_a & fwd1[XLEN-1];
    assign neg_b    = sgn_b & fwd2[XLEN-1];
    assign abs_a    = neg_a ? -fwd1 : fwd1;
    assign abs_b    = neg_b ? -fwd2 : fwd2;
    assign div_zero = (fwd2 == '0);
    assign div_ovf  = ~funct3[0] & (fwd1 == {1'b1, {(XLEN-1){1'b0}}}) & (&fwd2);
    assign go_div   = accept & md_en & md_div & ~(div_zero | div_ovf);

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] ext_a, ext_b, prod_f;
    assign ext_a  = {{XLEN{sgn_a & fwd1[XLEN-1]}}, fwd1};
    assign ext_b  = {{XLEN{sgn_b & fwd2[XLEN-1]}}, fwd2};
    assign prod_f = ext_a * ext_b;
    assign go_mul = 1'b0;
`else
    assign go_mul = accept & md_en & ~md_div;
`endif

    always_comb begin
        md_fast = '0;
        if (md_div) begin
            if (div_zero)
                md_fast = funct3[1] ? fwd1 : '1;
            else if (div_ovf)
                md_fast = funct3[1] ? '0 : fwd1;
        end else begin
`ifdef MDU_FAST_MUL_EN
            md_fast = (funct3[1:0] == 2'b00) ? prod_f[XLEN-1:0]
                                             : prod_f[2*XLEN-1:XLEN];
`endif
        end
    end

    assign result_c = md_en ? md_fast : ((is_jal | is_jalr) ? pc4 : alu_res);

    // one restoring-divide step and one shift-add multiply step per busy cycle
    logic [XLEN:0]     shifted, diff, msum;
    logic              ge;
    logic [XLEN-1:0]   rem_n, quo_n, md_res;
    logic [2*XLEN-1:0] acc_n, prod_i;

    assign shifted = {acc[XLEN-1:0], quo[XLEN-1]};
    assign diff    = shifted - {1'b0, dsr};
    assign ge      = ~diff[XLEN];
    assign rem_n   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_n   = {quo[XLEN-2:0], ge};
    assign msum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dsr} : '0);
    assign acc_n   = {msum, acc[XLEN-1:1]};
    assign prod_i  = m_neg_q ? -acc_n : acc_n;

    always_comb begin
        if (state == DIV_BUSY) begin
            if (m_op[1])
                md_res = m_neg_r ? -rem_n : rem_n;
            else
                md_res = m_neg_q ? -quo_n : quo_n;
        end else begin
            md_res = (m_op == 2'b00) ? prod_i[XLEN-1:0] : prod_i[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            acc           <= '0;
            quo           <= '0;
            dsr           <= '0;
            m_rs2         <= '0;
            m_neg_q       <= 1'b0;
            m_neg_r       <= 1'b0;
            m_rw          <= 1'b0;
            m_op          <= 2'b00;
            m_rd          <= 5'd0;
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_rs2       <= '0;
            out_rd        <= 5'd0;
            out_reg_write <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go_div || go_mul) begin
                        state   <= go_div ? DIV_BUSY : MUL_BUSY;
                        cnt     <= '0;
                        acc     <= go_div ? '0 : {{XLEN{1'b0}}, abs_a};
                        quo     <= abs_a;
                        dsr     <= abs_b;
                        m_neg_q <= neg_a ^ neg_b;
                        m_neg_r <= neg_a;
                        m_op    <= funct3[1:0];
                        m_rd    <= rd;
                        m_rw    <= reg_write;
                        m_rs2   <= fwd2;
                    end else if (accept) begin
                        out_valid     <= 1'b1;
                        out_result    <= result_c;
                        out_rs2       <= fwd2;
                        out_rd        <= rd;
                        out_reg_write <= reg_write;
                    end
                end
                default: begin
                    if (flush) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        if (state == DIV_BUSY) begin
                            acc[XLEN-1:0] <= rem_n;
                            quo           <= quo_n;
                        end else begin
                            acc <= acc_n;
                        end
                        if (cnt == LAST) begin
                            state         <= IDLE;
                            cnt           <= '0;
                            out_valid     <= 1'b1;
                            out_result    <= md_res;
                            out_rs2       <= m_rs2;
                            out_rd        <= m_rd;
                            out_reg_write <= m_rw;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// tb_ex_stage_mdu: directed checks of forwarding, ALU, branch recovery,
// multiply/divide latency, special divides, flush and reset for ex_stage_mdu.
`timescale 1ns/1ps
module tb_ex_stage_mdu;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_LAT  = 33;
    localparam int MUL_BUSY = 32;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [4:0]  rs1_addr, rs2_addr, rd;
    logic        reg_write;
    logic [31:0] rs1_data, rs2_data;
    logic        ex_mem_regwrite, mem_wb_regwrite;
    logic [4:0]  ex_mem_rd, mem_wb_rd;
    logic [31:0] ex_mem_data, mem_wb_data;
    logic [3:0]  alu_ctrl;
    logic        md_en;
    logic [2:0]  funct3;
    logic        alu_src, alu_src_a, is_lui, is_jal, is_jalr, branch;
    logic [31:0] imm, pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        out_valid;
    logic [31:0] out_result, out_rs2;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        branch_resolve;

    int checks   = 0;
    int failures = 0;
    int lat, busy;
    logic ghost;

    ex_stage_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd(rd),
        .reg_write(reg_write),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_regwrite(mem_wb_regwrite),
        .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .ex_mem_data(ex_mem_data), .mem_wb_data(mem_wb_data),
        .alu_ctrl(alu_ctrl), .md_en(md_en), .funct3(funct3),
        .alu_src(alu_src), .alu_src_a(alu_src_a), .is_lui(is_lui),
        .is_jal(is_jal), .is_jalr(is_jalr), .branch(branch),
        .imm(imm), .pc(pc),
        .pred_taken(pred_taken), .pred_pc(pred_pc),
        .out_valid(out_valid), .out_result(out_result), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_reg_write(out_reg_write),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .branch_resolve(branch_resolve)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; in_valid = 0;
        rs1_addr = 0; rs2_addr = 0; rd = 0; reg_write = 0;
        rs1_data = 0; rs2_data = 0;
        ex_mem_regwrite = 0; mem_wb_regwrite = 0;
        ex_mem_rd = 0; mem_wb_rd = 0; ex_mem_data = 0; mem_wb_data = 0;
        alu_ctrl = 0; md_en = 0; funct3 = 0;
        alu_src = 0; alu_src_a = 0; is_lui = 0;
        is_jal = 0; is_jalr = 0; branch = 0;
        imm = 0; pc = 0; pred_taken = 0; pred_pc = 0;
    endtask

    task automatic md_op(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, output int l, output int bz);
        idle();
        in_valid = 1; md_en = 1; funct3 = f3;
        rs1_addr = 5'd1; rs2_addr = 5'd2;
        rs1_data = a; rs2_data = b;
        rd = 5'd9; reg_write = 1;
        tick();
        idle();
        l = 1;
        bz = 0;
        while (!out_valid && l < 200) begin
            if (!in_ready) bz++;
            tick();
            l++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rs2", out_rs2, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_out_rw", {31'd0, out_reg_write}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1;
        tick();

        // forwarding priority
        in_valid = 1; rs1_addr = 5'd5; rs1_data = 32'h99;
        ex_mem_regwrite = 1; ex_mem_rd = 5'd5; ex_mem_data = 32'h10;
        mem_wb_regwrite = 1; mem_wb_rd = 5'd5; mem_wb_data = 32'h20;
        alu_src = 1; imm = 32'd1; rd = 5'd3; reg_write = 1;
        tick();
        chk("fwd_exmem_valid", {31'd0, out_valid}, 32'd1);
        chk("fwd_exmem", out_result, 32'h11);
        chk("fwd_rd", {27'd0, out_rd}, 32'd3);
        chk("fwd_rw", {31'd0, out_reg_write}, 32'd1);
        ex_mem_rd = 5'd0;
        tick();
        chk("fwd_memwb_valid", {31'd0, out_valid}, 32'd1);
        chk("fwd_memwb", out_result, 32'h21);
        idle();
        tick();
        chk("idle_no_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_hold", out_result, 32'h21);

        // ALU ops back to back
        in_valid = 1; alu_src = 1;
        rs1_data = 32'h8000_0000; imm = 32'd4; alu_ctrl = 4'd7;
        tick();
        chk("sra", out_result, 32'hF800_0000);
        rs1_data = 32'hFFFF_FFFF; imm = 32'd1; alu_ctrl = 4'd8;
        tick();
        chk("slt", out_result, 32'd1);
        alu_ctrl = 4'd9;
        tick();
        chk("sltu", out_result, 32'd0);
        rs1_data = 32'd3; imm = 32'd5; alu_ctrl = 4'd1;
        tick();
        chk("sub_wrap", out_result, 32'hFFFF_FFFE);
        alu_ctrl = 4'd12;
        tick();
        chk("bad_ctrl", out_result, 32'd0);
        alu_ctrl = 4'd0; is_lui = 1; imm = 32'h1234_5000;
        tick();
        chk("lui", out_result, 32'h1234_5000);
        chk("lui_valid", {31'd0, out_valid}, 32'd1);

        // branch recovery
        idle();
        in_valid = 1; branch = 1; funct3 = 3'd0;
        rs1_addr = 5'd1; rs2_addr = 5'd2; rs1_data = 32'd7; rs2_data = 32'd7;
        pc = 32'h100; imm = 32'h40; pred_taken = 0;
        #1;
        chk("beq_nt_pred_redirect", {31'd0, redirect}, 32'd1);
        chk("beq_nt_pred_pc", redirect_pc, 32'h140);
        chk("beq_resolve", {31'd0, branch_resolve}, 32'd1);
        tick();
        pred_taken = 1; pred_pc = 32'h140;
        #1;
        chk("beq_ok_redirect", {31'd0, redirect}, 32'd0);
        chk("beq_ok_resolve", {31'd0, branch_resolve}, 32'd1);
        tick();
        funct3 = 3'd1;
        #1;
        chk("bne_t_pred_redirect", {31'd0, redirect}, 32'd1);
        chk("bne_t_pred_pc", redirect_pc, 32'h104);
        tick();
        idle();
        in_valid = 1; is_jalr = 1; rs1_data = 32'h201; imm = 32'h10;
        pc = 32'h300; pred_taken = 1; pred_pc = 32'h210;
        #1;
        chk("jalr_redirect", {31'd0, redirect}, 32'd0);
        chk("jalr_resolve", {31'd0, branch_resolve}, 32'd1);
        tick();
        chk("jalr_link", out_result, 32'h304);
        idle();
        in_valid = 1; is_jal = 1; pc = 32'h400; imm = 32'h8; flush = 1;
        #1;
        chk("flush_redirect", {31'd0, redirect}, 32'd0);
        chk("flush_resolve", {31'd0, branch_resolve}, 32'd0);
        tick();
        chk("flush_blocks", {31'd0, out_valid}, 32'd0);
        chk("flush_hold", out_result, 32'h304);
        idle();

        // divide
        md_op(3'd4, 32'hFFFF_FFEC, 32'd3, lat, busy);
        chk("div_lat", lat, 32'd33);
        chk("div_busy", busy, 32'd32);
        chk("div_q", out_result, 32'hFFFF_FFFA);
        chk("div_rd", {27'd0, out_rd}, 32'd9);
        chk("div_ready", {31'd0, in_ready}, 32'd1);
        md_op(3'd6, 32'hFFFF_FFEC, 32'd3, lat, busy);
        chk("rem_lat", lat, 32'd33);
        chk("rem_r", out_result, 32'hFFFF_FFFE);

        // divide special cases
        md_op(3'd5, 32'd5, 32'd0, lat, busy);
        chk("divu0_lat", lat, 32'd1);
        chk("divu0_q", out_result, 32'hFFFF_FFFF);
        md_op(3'd7, 32'd5, 32'd0, lat, busy);
        chk("remu0_r", out_result, 32'd5);
        md_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy);
        chk("ovf_lat", lat, 32'd1);
        chk("ovf_busy", busy, 32'd0);
        chk("ovf_q", out_result, 32'h8000_0000);
        md_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy);
        chk("ovf_r", out_result, 32'd0);

        // flush mid-divide
        idle();
        in_valid = 1; md_en = 1; funct3 = 3'd4;
        rs1_data = 32'd100; rs2_data = 32'd7; rd = 5'd6; reg_write = 1;
        tick();
        idle();
        repeat (9) tick();
        flush = 1;
        tick();
        flush = 0;
        chk("flush_div_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_div_valid", {31'd0, out_valid}, 32'd0);
        ghost = 0;
        repeat (40) begin
            if (out_valid) ghost = 1;
            tick();
        end
        chk("flush_div_ghost", {31'd0, ghost}, 32'd0);
        in_valid = 1; rs1_data = 32'd2; rs2_data = 32'd3; rd = 5'd4;
        tick();
        chk("post_flush_valid", {31'd0, out_valid}, 32'd1);
        chk("post_flush_add", out_result, 32'd5);
        idle();

        // multiply
        md_op(3'd2, 32'hFFFF_FFFF, 32'd2, lat, busy);
        chk("mulhsu_lat", lat, MUL_LAT);
        chk("mulhsu_busy", busy, MUL_BUSY);
        chk("mulhsu", out_result, 32'hFFFF_FFFF);
        md_op(3'd0, 32'd7, 32'hFFFF_FFFD, lat, busy);
        chk("mul_lo", out_result, 32'hFFFF_FFEB);
        md_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busy);
        chk("mulhu", out_result, 32'hFFFF_FFFE);
        md_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busy);
        chk("mulh", out_result, 32'd0);

        // reset in the middle of a divide
        idle();
        in_valid = 1; md_en = 1; funct3 = 3'd5;
        rs1_data = 32'd50; rs2_data = 32'd5; rd = 5'd7; reg_write = 1;
        tick();
        idle();
        repeat (3) tick();
        #2;
        rst = 0;
        #1;
        chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_result", out_result, 32'd0);
        chk("rst_mid_rd", {27'd0, out_rd}, 32'd0);
        tick();
        rst = 1;
        ghost = 0;
        repeat (40) begin
            if (out_valid) ghost = 1;
            tick();
        end
        chk("rst_mid_ghost", {31'd0, ghost}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stage_mdu.md
# ex_stage_mdu

Parametrised execute stage for the pipelined RISC-V core. It sits between the ID/EX and EX/MEM boundaries and keeps operand forwarding, ALU and branch resolution. It adds the RV32M multiply/divide unit with an iterative divider and a busy/ready handshake, a registered EX/MEM output, flush handling, and full misprediction recovery (taken and not-taken).

## Interface
- `XLEN`, 32: datapath width (≥ 8, power of 2)
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `flush` in 1: synchronous kill of the current and in-flight instruction
- `in_valid` / `in_ready` in/out 1: ID/EX handshake; an instruction is accepted when both are high
- `rs1_addr`, `rs2_addr`, `rd` in 5: source and destination registers; `reg_write` in 1
- `rs1_data`, `rs2_data` in XLEN: register file data
- `ex_mem_regwrite`, `mem_wb_regwrite` in 1; `ex_mem_rd`, `mem_wb_rd` in 5; `ex_mem_data`, `mem_wb_data` in XLEN: forwarding sources
- `alu_ctrl` in 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU; other codes give 0
- `md_en` in 1: M-extension op; `funct3` in 3 selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, and branch condition
- `alu_src`, `alu_src_a`, `is_lui`, `is_jal`, `is_jalr`, `branch` in 1; `imm`, `pc` in XLEN
- `pred_taken` in 1, `pred_pc` in XLEN: fetch prediction
- `out_valid` out 1; `out_result`, `out_rs2` out XLEN; `out_rd` out 5; `out_reg_write` out 1: registered EX/MEM
- `redirect` out 1, `redirect_pc` out XLEN: mispredict recovery (combinational)
- `branch_resolve` out 1: resolve pulse for the BPU (combinational)

## Operation
- **Forwarding:** EX/MEM has priority over MEM/WB, and a forwarding source matches only if its regwrite is high and its rd ≠ 0.
- **Operand A:** 0 if `is_lui`, `pc` if `alu_src_a`, otherwise forwarded rs1.
- **Operand B:** `imm` if `alu_src`, otherwise forwarded rs2.
- **Result:** for jal/jalr, `pc+4`; otherwise the ALU result. Shift amounts use the low log2(XLEN) bits. All arithmetic wraps modulo 2^XLEN.
- **Branch condition (funct3):** 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU.
- **Target:**
  - jalr: `(rs1 + imm) & ~1`.
  - Other branches and jumps: `pc + imm`.
  - actual_next = target if (jal | jalr | taken branch), else `pc + 4`.
- **Misprediction:** `redirect` = accept & (jal|jalr|branch) & ((pred_taken ≠ actually_taken) | (actually_taken & pred_pc ≠ target)). `redirect_pc` = actual_next.
- **Resolve:** `branch_resolve` = accept & (jal|jalr|branch).
- **md_en ops:** no redirect and no branch resolve.
- **FSM states:** IDLE, MUL_BUSY, DIV_BUSY.
  - IDLE, accept md_en multiply → MUL_BUSY; accept divide/rem (non-special) → DIV_BUSY; otherwise stay.
  - BUSY → IDLE when the iteration counter reaches its terminal count, or on `flush`.
  - `in_ready` = (state == IDLE). Operands, rd, reg_write and funct3 are latched at acceptance.
- **Divider:** restoring division on magnitudes, XLEN iterations, with sign fix-up at completion. DIV/REM signed; DIVU/REMU unsigned.
- **Divide special cases** (detected at accept, complete with ALU latency, no busy):
  - divisor 0 → quotient all-ones, remainder = dividend.
  - signed overflow (−2^(XLEN−1) / −1) → quotient = dividend, remainder 0.
- **MULH/MULHSU/MULHU:** return the upper XLEN bits of the 2·XLEN-bit product, with signedness per RISC-V. MUL returns the lower XLEN bits.

## Timing
- **Reset values:** state IDLE; `out_valid` 0; `out_result`, `out_rs2`, `out_rd` 0; `out_reg_write` 0; counter 0. `in_ready` is 1 after reset.
- **ALU/branch/jump:** accepted in cycle 0; `out_valid` = 1 in cycle 1 for exactly one cycle. `redirect` and `branch_resolve` are asserted in cycle 0.
- **Divide:** accepted in cycle 0; `in_ready` = 0 in cycles 1..XLEN; `out_valid` pulses in cycle XLEN+1; `in_ready` = 1 in cycle XLEN+1.
- **Multiply:** latency per Configuration; `in_ready` is low while busy.
- **Back-to-back:** single-cycle ops sustain one instruction per cycle.
- **`flush`:**
  - Blocks acceptance in the same cycle (`flush` wins over `in_valid`).
  - Aborts any busy op; state returns to IDLE in the next cycle.
  - Forces `out_valid` = 0 in the next cycle, and no result of the killed op is ever emitted.
- **Reset mid-operation:** immediate return to the reset values; no output pulse.
- **Idle cycles:** when nothing is accepted, `out_valid` = 0 and the other out_* registers hold their values.

## Configuration
- **`MDU_FAST_MUL_EN`:**
  - Defined: single-cycle combinational XLEN×XLEN product, registered with ALU latency 1; no MUL_BUSY.
  - Undefined: iterative shift-add, XLEN iterations, `out_valid` in cycle XLEN+1. The handshake is identical to divide.
- Divide is always iterative.

## Test plan
- **Forwarding priority:** rs1_addr=5, ex_mem_rd=5 with data 0x10, mem_wb_rd=5 with data 0x20, ADD imm=1 → out_result=0x11. With ex_mem_rd=0 → out_result=0x21.
- **Not-taken mispredict:** BEQ rs1=rs2=7, pc=0x100, imm=0x40, pred_taken=0 → redirect=1, redirect_pc=0x140. Same branch with pred_taken=1 and pred_pc=0x140 → redirect=0, branch_resolve=1.
- **Divide latency:** DIV −20/3, XLEN=32 → in_ready low for 32 cycles; out_valid in cycle 33; result 0xFFFFFFFA. REM of the same operands → 0xFFFFFFFE.
- **Divide special cases:** DIVU 5/0 → 0xFFFFFFFF in cycle 1. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM for both cases → 5 and 0 respectively.
- **Flush mid-divide:** flush in cycle 10 of a DIV → no out_valid for that op, in_ready=1 in cycle 11. A following ADD 2+3 completes with out_result=5.
- **MULHSU:** 0xFFFFFFFF × 2 → 0xFFFFFFFF. Latency is 1 with MDU_FAST_MUL_EN and 33 without it.
